wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order WB stage and a multi-cycle mul/div unit (MDU) that completes out of order.
- MDU results are buffered in a small FIFO and drained in cycles where the WB stage does not write.
- A starvation limit forces a one-cycle pipeline stall so buffered results always retire.
- Sits between WB_stage/MDU and the register file write port.

---
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// WB stage and the out-of-order mul/div unit. MDU results wait in a small
// FIFO and drain in cycles where WB does not write. A starvation counter
// stalls WB for one cycle so buffered results always retire.
// Optional build macro WB_ARB_STATS_EN adds the stall_cycles counter output.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_wdata,
    output logic            mdu_ready,
    output logic            pipe_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_rd   [DEPTH];
    logic [XLEN-1:0]  ent_data [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve_cnt;

    logic pipe_eff;
    logic head_v;
    logic stall;
    logic grant_pipe;
    logic grant_head;
    logic do_enq;

    // Arbitration: WB wins unless the FIFO head has starved for the limit.
    always_comb begin
        pipe_eff   = pipe_we && (pipe_rd != 5'd0);
        head_v     = (count != '0);
        mdu_ready  = (count != FULL_CNT);
        stall      = pipe_eff && head_v && (starve_cnt == STARVE_MAX);
        grant_pipe = pipe_eff && !stall;
        grant_head = head_v && (!pipe_eff || stall);
        do_enq     = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
        pipe_stall = stall;
    end

    // FIFO bookkeeping: kill older entries overwritten by WB, pop, push.
    // The push comes last so a same-cycle entry to the killed rd survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (grant_pipe && ent_valid[i] && (ent_rd[i] == pipe_rd))
                    ent_valid[i] <= 1'b0;
            end
            if (grant_head) begin
                ent_valid[head_ptr] <= 1'b0;
                head_ptr            <= head_ptr + PTR_W'(1);
            end
            if (do_enq) begin
                ent_valid[tail_ptr] <= 1'b1;
                tail_ptr            <= tail_ptr + PTR_W'(1);
            end
            case ({do_enq, grant_head})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            ent_rd[tail_ptr]   <= mdu_rd;
            ent_data[tail_ptr] <= mdu_wdata;
        end
    end

    // Starvation counter: counts head losses, clears on head grant or empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_head || !head_v) begin
            starve_cnt <= '0;
        end else if (grant_pipe && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Registered write port; a killed head drains without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_pipe || (grant_head && ent_valid[head_ptr]);
            if (grant_pipe) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_wdata;
            end else if (grant_head) begin
                rf_waddr <= ent_rd[head_ptr];
                rf_wdata <= ent_data[head_ptr];
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_wdata;
    logic            mdu_valid;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_wdata;
    logic            mdu_ready;
    logic            pipe_stall;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [31:0]     stall_cycles;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH(2),
        .STARVE_LIMIT(4),
        .XLEN(XLEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pipe_we(pipe_we),
        .pipe_rd(pipe_rd),
        .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid),
        .mdu_rd(mdu_rd),
        .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready),
        .pipe_stall(pipe_stall),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
`ifdef WB_ARB_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
            chk({tag, "_data"}, rf_wdata, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we    = 1'b0;
        pipe_rd    = 5'd0;
        pipe_wdata = '0;
        mdu_valid  = 1'b0;
        mdu_rd     = 5'd0;
        mdu_wdata  = '0;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_mdu_ready", 32'(mdu_ready), 32'd1);
        chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // WB write, one-cycle latency
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'h11;
        #1 chk("t1_stall", 32'(pipe_stall), 32'd0);
        tick();
        chk_rf("t1", 1'b1, 5'd5, 32'h11);
        idle_inputs();

        // MDU result, drains two edges later
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wdata = 32'hABCD;
        #1 chk("t2_ready", 32'(mdu_ready), 32'd1);
        tick();
        chk_rf("t2_nobypass", 1'b0, 5'd0, 32'd0);
        idle_inputs();
        tick();
        chk_rf("t2", 1'b1, 5'd7, 32'hABCD);

        // Starvation: enqueue rd=3 alongside continuous WB writes to rd=9
        pipe_we = 1'b1; pipe_rd = 5'd9; pipe_wdata = 32'h90;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_wdata = 32'h33;
        tick();
        chk_rf("t3_a", 1'b1, 5'd9, 32'h90);
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wdata = '0;
        for (int k = 1; k <= 4; k++) begin
            pipe_wdata = 32'h90 + 32'(k);
            #1 chk("t3_nostall", 32'(pipe_stall), 32'd0);
            tick();
            chk_rf("t3_pipe", 1'b1, 5'd9, 32'h90 + 32'(k));
        end
        pipe_wdata = 32'h95;
        #1 chk("t3_stall", 32'(pipe_stall), 32'd1);
        tick();
        chk_rf("t3_head", 1'b1, 5'd3, 32'h33);
        #1 chk("t3_unstall", 32'(pipe_stall), 32'd0);
        tick();
        chk_rf("t3_held", 1'b1, 5'd9, 32'h95);
`ifdef WB_ARB_STATS_EN
        chk("t3_stall_cycles", stall_cycles, 32'd1);
`endif
        idle_inputs();

        // Fill FIFO while WB busy; third result waits for a free slot
        pipe_we = 1'b1; pipe_rd = 5'd10; pipe_wdata = 32'hA0;
        mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_wdata = 32'h1001;
        #1 chk("t4_ready0", 32'(mdu_ready), 32'd1);
        tick();
        pipe_wdata = 32'hA1;
        mdu_rd = 5'd2; mdu_wdata = 32'h2002;
        #1 chk("t4_ready1", 32'(mdu_ready), 32'd1);
        tick();
        chk_rf("t4_pipe", 1'b1, 5'd10, 32'hA1);
        pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wdata = '0;
        mdu_rd = 5'd11; mdu_wdata = 32'h3003;
        #1 chk("t4_full", 32'(mdu_ready), 32'd0);
        tick();
        chk_rf("t4_drain1", 1'b1, 5'd1, 32'h1001);
        #1 chk("t4_ready_after", 32'(mdu_ready), 32'd1);
        tick();
        chk_rf("t4_drain2", 1'b1, 5'd2, 32'h2002);
        idle_inputs();
        tick();
        chk_rf("t4_drain3", 1'b1, 5'd11, 32'h3003);
        tick();
        chk_rf("t4_empty", 1'b0, 5'd0, 32'd0);

        // Ordering kill: WB write to rd=4 supersedes buffered rd=4
        pipe_we = 1'b1; pipe_rd = 5'd12; pipe_wdata = 32'hC0;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_wdata = 32'h1;
        tick();
        chk_rf("t5_pipe", 1'b1, 5'd12, 32'hC0);
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wdata = '0;
        pipe_rd = 5'd4; pipe_wdata = 32'h2;
        tick();
        chk_rf("t5_new", 1'b1, 5'd4, 32'h2);
        idle_inputs();
        tick();
        chk_rf("t5_killed", 1'b0, 5'd0, 32'd0);
        tick();
        chk_rf("t5_empty", 1'b0, 5'd0, 32'd0);

        // Same-cycle WB write and MDU enqueue to rd=13: new entry survives
        pipe_we = 1'b1; pipe_rd = 5'd13; pipe_wdata = 32'hD0;
        mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_wdata = 32'hD1;
        tick();
        chk_rf("t6_pipe", 1'b1, 5'd13, 32'hD0);
        idle_inputs();
        tick();
        chk_rf("t6_young", 1'b1, 5'd13, 32'hD1);

        // x0 handling on both sources
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wdata = 32'hEE;
        mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_wdata = 32'h66;
        #1 chk("t7_stall0", 32'(pipe_stall), 32'd0);
        tick();
        chk_rf("t7_x0pipe", 1'b0, 5'd0, 32'd0);
        mdu_rd = 5'd0; mdu_wdata = 32'h77;
        #1 chk("t7_stall1", 32'(pipe_stall), 32'd0);
        chk("t7_ready", 32'(mdu_ready), 32'd1);
        tick();
        chk_rf("t7_drain", 1'b1, 5'd6, 32'h66);
        idle_inputs();
        tick();
        chk_rf("t7_x0mdu", 1'b0, 5'd0, 32'd0);

        // Reset with two buffered entries drops them
        pipe_we = 1'b1; pipe_rd = 5'd14; pipe_wdata = 32'hE0;
        mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_wdata = 32'h88;
        tick();
        mdu_rd = 5'd9; mdu_wdata = 32'h99;
        tick();
        chk_rf("t8_pipe", 1'b1, 5'd14, 32'hE0);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("t8_rst_we", 32'(rf_we), 32'd0);
        chk("t8_rst_ready", 32'(mdu_ready), 32'd1);
        chk("t8_rst_stall", 32'(pipe_stall), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_rf("t8_post", 1'b0, 5'd0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
